// File: rtl/instr_rom_arbiter.sv
// rtl/instr_rom_arbiter.sv - two-master arbiter for the shared synchronous-read instruction ROM
//
// Master 0 is the core instruction fetch, master 1 the debug/UART read-back.
// At most one read is granted per cycle; the ROM data returned one cycle later
// is flagged valid only to the master that owned the grant.
//
// Build option: define INSTR_ROM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, master 0 has fixed priority and a starvation counter forces a
// master 1 grant after STARVE_LIMIT contended cycles.

module instr_rom_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata
);

  // Which master the read issued last cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  owner_t            owner;
  owner_t            owner_next;
  logic [ADDR_W-1:0] last_addr;
  logic              grant0;
  logic              grant1;
  logic              pick_m1;   // winner when both masters request

`ifdef INSTR_ROM_ARB_ROUND_ROBIN_EN

  // rr_ptr names the preferred master; 0 = m0, 1 = m1.
  logic rr_ptr;

  // After any grant, preference passes to the master that was not served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (grant0) begin
      rr_ptr <= 1'b1;
    end else if (grant1) begin
      rr_ptr <= 1'b0;
    end
  end

  assign pick_m1 = rr_ptr;

`else

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;

  // Count cycles master 1 waits; any m1 grant or dropped request restarts it.
  // The count never exceeds LIMIT in practice because reaching it forces the
  // next contended grant to m1; the saturation guard is only a backstop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 8'd0;
    end else if (!m1_req || grant1) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != 8'hFF) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  assign pick_m1 = (starve_cnt >= LIMIT);

`endif

  // Grant decision: a lone request wins outright, contention uses pick_m1.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        grant1 = pick_m1;
        grant0 = !pick_m1;
      end else begin
        grant0 = m0_req;
        grant1 = m1_req;
      end
    end
  end

  assign m0_gnt = grant0;
  assign m1_gnt = grant1;

  // ROM address follows the granted master, otherwise holds the last one so
  // the ROM input does not toggle on idle cycles.
  always_comb begin
    rom_addr = last_addr;
    if (rst) begin
      rom_addr = '0;
    end else if (grant0) begin
      rom_addr = m0_addr;
    end else if (grant1) begin
      rom_addr = m1_addr;
    end
  end

  // Remember the most recently granted address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr <= '0;
    end else if (grant0 || grant1) begin
      last_addr <= rom_addr;
    end
  end

  // Owner register: reset discards any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_next;
    end
  end

  // Next owner is whichever master was granted this cycle.
  always_comb begin
    owner_next = OWN_NONE;
    if (grant0) begin
      owner_next = OWN_M0;
    end else if (grant1) begin
      owner_next = OWN_M1;
    end
  end

  assign m0_rvalid = (owner == OWN_M0);
  assign m1_rvalid = (owner == OWN_M1);

  // Both data outputs carry the ROM word; each is qualified by its own rvalid.
  assign m0_rdata = rom_rdata;
  assign m1_rdata = rom_rdata;

`ifndef SYNTHESIS
  a_one_grant: assert property (@(posedge clk) disable iff (rst) !(m0_gnt && m1_gnt));
`endif

endmodule

// File: tb/tb_instr_rom_arbiter.sv
// tb/tb_instr_rom_arbiter.sv - directed self-checking bench for instr_rom_arbiter

module tb_instr_rom_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rdata;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [0:63];

  instr_rom_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m0_req(m0_req),
    .m0_addr(m0_addr),
    .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req),
    .m1_addr(m1_addr),
    .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .rom_addr(rom_addr),
    .rom_rdata(rom_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read ROM model with one cycle latency; unloaded words read 0.
  always @(posedge clk) begin
    if (rom_addr[ADDR_W-1:8] == '0) rom_rdata <= mem[rom_addr[7:2]];
    else                            rom_rdata <= '0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
    m0_addr = 14'h040; m1_addr = 14'h044;
    @(posedge clk); #1;
    @(posedge clk); #3;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt});
    end
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid});
    end
    checks++;
    if (rom_addr !== 14'h000) begin
      errors++; $display("FAIL reset_rom_addr: got %h expected 0000", rom_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL reset_release_gnt: got %b expected 10", {m0_gnt, m1_gnt});
    end
    checks++;
    if (rom_addr !== 14'h040) begin
      errors++; $display("FAIL reset_release_addr: got %h expected 0040", rom_addr);
    end
    @(posedge clk); #1;
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b10) begin
      errors++; $display("FAIL reset_release_rvalid: got %b expected 10", {m0_rvalid, m1_rvalid});
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_solo_stream();
    logic [DATA_W-1:0] exp_word [0:2];
    exp_word[0] = 32'h20006513; exp_word[1] = 32'h0c800593; exp_word[2] = 32'h05600613;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      m0_req = 1'b1; m0_addr = 14'(4 * i);
      #2;
      checks++;
      if ({m0_gnt, m1_gnt, rom_addr} !== {2'b10, 14'(4 * i)}) begin
        errors++; $display("FAIL solo_gnt[%0d]: got gnt=%b addr=%h expected gnt=10 addr=%h",
                           i, {m0_gnt, m1_gnt}, rom_addr, 14'(4 * i));
      end
      @(posedge clk); #1;
      checks++;
      if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, exp_word[i]}) begin
        errors++; $display("FAIL solo_data[%0d]: got rv=%b data=%h expected rv=10 data=%h",
                           i, {m0_rvalid, m1_rvalid}, m0_rdata, exp_word[i]);
      end
    end
    m0_req = 1'b0;
    #2;
    checks++;
    if ({m0_gnt, m1_gnt, rom_addr} !== {2'b00, 14'h008}) begin
      errors++; $display("FAIL solo_idle_addr: got gnt=%b addr=%h expected gnt=00 addr=0008",
                         {m0_gnt, m1_gnt}, rom_addr);
    end
    @(posedge clk); #1;
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      errors++; $display("FAIL solo_idle_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid});
    end
  endtask

  task automatic test_interleave();
    do_reset();
    m0_req = 1'b1; m0_addr = 14'h010;
    #2;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL inter_gnt0: got %b expected 10", {m0_gnt, m1_gnt});
    end
    @(posedge clk); #1;
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 32'h01200713}) begin
      errors++; $display("FAIL inter_data0: got rv=%b data=%h expected rv=10 data=01200713",
                         {m0_rvalid, m1_rvalid}, m0_rdata);
    end
    m0_req = 1'b0; m1_req = 1'b1; m1_addr = 14'h014;
    #2;
    checks++;
    if ({m0_gnt, m1_gnt, rom_addr} !== {2'b01, 14'h014}) begin
      errors++; $display("FAIL inter_gnt1: got gnt=%b addr=%h expected gnt=01 addr=0014",
                         {m0_gnt, m1_gnt}, rom_addr);
    end
    @(posedge clk); #1;
    checks++;
    if ({m0_rvalid, m1_rvalid, m1_rdata} !== {2'b01, 32'h00b50023}) begin
      errors++; $display("FAIL inter_data1: got rv=%b data=%h expected rv=01 data=00b50023",
                         {m0_rvalid, m1_rvalid}, m1_rdata);
    end
    m1_req = 1'b0;
  endtask

  // Drives both requests for n cycles (m1 dropped at drop_at) and checks the
  // grant pattern against exp_m1, a bit mask of cycles where m1 should win.
  task automatic run_contention(input string name, input int n, input int drop_at,
                                input logic [31:0] exp_m1);
    logic g1;
    do_reset();
    m0_addr = 14'h000; m1_addr = 14'h004;
    for (int c = 0; c < n; c++) begin
      m0_req = 1'b1; m1_req = (c != drop_at);
      g1 = exp_m1[c];
      #2;
      checks++;
      if ({m0_gnt, m1_gnt} !== {!g1, g1}) begin
        errors++; $display("FAIL %s_gnt[%0d]: got %b expected %b",
                           name, c, {m0_gnt, m1_gnt}, {!g1, g1});
      end
      @(posedge clk); #1;
      checks++;
      if ({m0_rvalid, m1_rvalid} !== {!g1, g1} ||
          (g1 ? m1_rdata : m0_rdata) !== (g1 ? 32'h0c800593 : 32'h20006513)) begin
        errors++; $display("FAIL %s_route[%0d]: got rv=%b d0=%h d1=%h expected rv=%b",
                           name, c, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, {!g1, g1});
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_arbitration();
`ifdef INSTR_ROM_ARB_ROUND_ROBIN_EN
    run_contention("rr", 8, -1, 32'b1010_1010);
`else
    // m1 forced at cycles 8 and 17 of a continuous contention run.
    run_contention("starve", 18, -1, 32'h0002_0100);
    // m1 drops at cycle 5, clearing the counter; next forced grant is cycle 14.
    run_contention("starve_clear", 15, 5, 32'h0000_4000);
`endif
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m1_req = 1'b1; m1_addr = 14'h014;
    #2;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      errors++; $display("FAIL midrst_gnt: got %b expected 01", {m0_gnt, m1_gnt});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, rom_addr} !== {2'b00, 14'h000}) begin
      errors++; $display("FAIL midrst_during: got gnt=%b addr=%h expected gnt=00 addr=0000",
                         {m0_gnt, m1_gnt}, rom_addr);
    end
    @(posedge clk); #1;
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      errors++; $display("FAIL midrst_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid});
    end
    rst = 1'b0; m1_req = 1'b0;
    #2;
    checks++;
    if (rom_addr !== 14'h000) begin
      errors++; $display("FAIL midrst_last_addr: got %h expected 0000", rom_addr);
    end
    @(posedge clk); #1;
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      errors++; $display("FAIL midrst_owner: got %b expected 00", {m0_rvalid, m1_rvalid});
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 32'h20006513;
    mem[1] = 32'h0c800593;
    mem[2] = 32'h05600613;
    mem[4] = 32'h01200713;
    mem[5] = 32'h00b50023;
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;

    test_reset();
    test_solo_stream();
    test_interleave();
    test_arbitration();
    test_reset_mid_read();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_rom_arbiter.md
# instr_rom_arbiter

Two-port arbiter that shares the single synchronous-read instruction ROM between the core's instruction-fetch port (master 0) and the debug/UART read-back port (master 1). It grants at most one request per cycle, drives the ROM address, and routes the ROM's registered read data back to the master that issued the request. It sits between the core/debug logic and the instruction ROM; the ROM keeps its fixed 1-cycle read latency.

## Interface
- ADDR_W, 14, byte-address width, matching the ROM `i_addr`.
- DATA_W, 32, instruction word width.
- STARVE_LIMIT, 8, cycles master 1 may wait under contention before a forced grant (fixed-priority mode only); legal range 1..255.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  fetch request; held with m0_addr stable until m0_gnt.
- m0_addr  in  ADDR_W  fetch byte address.
- m0_gnt  out  1  fetch request accepted this cycle (combinational).
- m0_rvalid  out  1  m0_rdata valid (registered, one cycle after m0_gnt).
- m0_rdata  out  DATA_W  fetch read data.
- m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for the debug port.
- rom_addr  out  ADDR_W  ROM address.
- rom_rdata  in  DATA_W  ROM registered output, valid one cycle after rom_addr.

## Operation
- Grant per cycle: neither req gives no grant. A single req is granted immediately. If both assert, the priority rule below applies. m0_gnt and m1_gnt are never both 1.
- rom_addr is the granted master's address in the grant cycle. With no grant, it is last_addr, a register holding the most recent granted address (reset 0).
- owner register (none/m0/m1) captures the granted master at each clock edge. The next cycle asserts only that master's rvalid. m0_rdata and m1_rdata both pass rom_rdata through; they are meaningful only with their own rvalid.
- Back-to-back grants are legal: throughput is 1 read per cycle total.
- The arbiter does not check addresses. Out-of-range words return whatever the ROM outputs (0).
- Fixed-priority mode (macro absent):
  - m0 wins contention.
  - starve_cnt (8-bit) increments each cycle that m1_req=1 and m1 is not granted.
  - starve_cnt clears on an m1 grant or when m1_req=0.
  - When starve_cnt reaches STARVE_LIMIT, m1 wins the next contended cycle.

## Timing
- Grant latency is 0 cycles (combinational from req).
- Data latency is 1 cycle: rvalid and rdata appear at cycle N+1 for a grant at cycle N.
- Reset values: m0_rvalid=0, m1_rvalid=0, owner=none, last_addr=0, starve_cnt=0, rr_ptr=m0.
- While rst=1, m0_gnt=0, m1_gnt=0 and rom_addr=0.
- Reset asserted with a read outstanding: the read is discarded and no rvalid follows. The first grant is possible in the first cycle with rst=0.
- A master dropping req before gnt is legal. No state changes except starve_cnt clearing.
- Simultaneous m1 grant and starve_cnt at STARVE_LIMIT: the counter clears and does not wrap.

## Configuration
- INSTR_ROM_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration using a 1-bit rr_ptr naming the preferred master.
  - On any grant, rr_ptr moves to the non-granted master.
  - starve_cnt and STARVE_LIMIT are unused; the counter is not instantiated.
- Macro absent: fixed priority with the starvation counter, as in Operation.

## Test plan
- Reset: hold rst=1 with both reqs=1 -> no gnt, rvalid=0, rom_addr=0. Release rst -> m0_gnt=1 that cycle, m0_rvalid=1 next cycle.
- Solo fetch stream: m0_req=1 with addr 0x00, 0x04, 0x08 on consecutive cycles, ROM loaded with 0x20006513, 0x0c800593, 0x05600613 -> m0_rvalid=1 for 3 cycles with those words in order. m1_rvalid=0 throughout.
- Interleave: m0 grant at cycle N (addr 0x10), m1 grant at N+1 (addr 0x14) -> m0 gets 0x01200713 at N+1 and m1 gets 0x00b50023 at N+2. Neither rvalid is set at the other's cycle.
- Fixed-priority starvation (STARVE_LIMIT=8, macro absent): both reqs held continuously -> m0 granted cycles 0..7, m1 granted cycle 8, m0 resumes cycle 9. The pattern repeats every 9 cycles.
- Round-robin (macro defined): both reqs held -> grants alternate m0, m1, m0, m1 from reset, and each rvalid is routed correctly.
- Reset mid-read: grant m1 at cycle N, assert rst at N+0.5 -> m1_rvalid stays 0 at N+1. After release, last_addr=0 and owner=none.
